// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller and its helpers.
package pipe_ctrl_pkg;

    // FSM state encodings; 2'd3 is unused and treated as RUN
    localparam logic [1:0] ST_RUN = 2'd0;
    localparam logic [1:0] ST_MDU = 2'd1;
    localparam logic [1:0] ST_MEM = 2'd2;
    localparam logic [1:0] ST_ILL = 2'd3;

    // Architectural zero register; writes to it never create a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Width of the multiply/divide hold counter (MDU_LAT up to 15)
    localparam int unsigned MDU_CNT_W = 4;

    // Pipeline register controls driven as one bundle
    typedef struct packed {
        logic pc_wen;
        logic ifid_wen;
        logic idex_wen;
        logic exmem_wen;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } pipe_ctl_t;

    // Normal advance: every register loads, nothing is squashed
    localparam pipe_ctl_t CTL_ADVANCE = '{
        pc_wen: 1'b1, ifid_wen: 1'b1, idex_wen: 1'b1, exmem_wen: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0
    };

    // Held in reset: nothing loads, every register is forced to a bubble
    localparam pipe_ctl_t CTL_RESET = '{
        pc_wen: 1'b0, ifid_wen: 1'b0, idex_wen: 1'b0, exmem_wen: 1'b0,
        ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1
    };

    // Whole pipe frozen while data memory is busy
    localparam pipe_ctl_t CTL_FREEZE = '{
        pc_wen: 1'b0, ifid_wen: 1'b0, idex_wen: 1'b0, exmem_wen: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0
    };

    // Data memory has an outstanding access that does not complete this cycle
    function automatic logic mem_freeze(input logic req, input logic ready);
        return req & ~ready;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: the EX load produces a register the ID
// instruction is about to read. Shared with the forwarding unit.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_mem_ren,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       lu_c
);

    logic rs_hit_c;
    logic rt_hit_c;

    // rt only matters when the ID instruction actually sources it
    always_comb begin
        rs_hit_c = (ex_rd == id_rs);
        rt_hit_c = id_uses_rt & (ex_rd == id_rt);
        lu_c     = ex_mem_ren & (ex_rd != REG_ZERO) & (rs_hit_c | rt_hit_c);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller for the five-stage core: load-use bubbles,
// branch squash, multi-cycle MDU hold in EX and data-memory freeze.
// Optional statistics counters are built when HAZ_STATS_EN is defined.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 32
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_mdu_start,
    input  logic             ex_mem_ren,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             idex_wen,
    output logic             exmem_wen,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       state
`ifdef HAZ_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    logic [1:0]           state_q;
    logic [1:0]           state_nxt;
    logic [MDU_CNT_W-1:0] mdu_cnt_q;
    logic [MDU_CNT_W-1:0] mdu_cnt_nxt;
    logic                 frz_c;
    logic                 lu_c;
    logic                 bubble_c;
    pipe_ctl_t            ctl_c;

    // Load-use comparator
    load_use_detect u_lu (
        .ex_mem_ren (ex_mem_ren),
        .ex_rd      (ex_rd),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .lu_c       (lu_c)
    );

    assign frz_c = mem_freeze(mem_req, mem_ready);

    // State and MDU hold counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            mdu_cnt_q <= '0;
        end else begin
            state_q   <= state_nxt;
            mdu_cnt_q <= mdu_cnt_nxt;
        end
    end

    // Next state, counter and pipeline controls; priority frz > MDU > branch > lu > MDU start
    always_comb begin
        ctl_c       = CTL_ADVANCE;
        state_nxt   = state_q;
        mdu_cnt_nxt = mdu_cnt_q;
        bubble_c    = 1'b0;

        if (!reset) begin
            ctl_c       = CTL_RESET;
            state_nxt   = ST_RUN;
            mdu_cnt_nxt = '0;
        end else if (frz_c) begin
            // Freeze keeps an MDU op pending; otherwise park in MEM_WAIT
            ctl_c     = CTL_FREEZE;
            state_nxt = (state_q == ST_MDU) ? ST_MDU : ST_MEM;
        end else if (state_q == ST_MDU) begin
            // Hold PC/IF/ID, let EX/MEM take bubbles behind the MDU op
            ctl_c.pc_wen      = 1'b0;
            ctl_c.ifid_wen    = 1'b0;
            ctl_c.idex_wen    = 1'b0;
            ctl_c.exmem_flush = 1'b1;
            if (mdu_cnt_q <= MDU_CNT_W'(1)) begin
                mdu_cnt_nxt = '0;
                state_nxt   = ST_RUN;
            end else begin
                mdu_cnt_nxt = mdu_cnt_q - MDU_CNT_W'(1);
            end
        end else begin
            // RUN, released MEM_WAIT and the illegal code all behave as RUN
            state_nxt = ST_RUN;
            if (ex_branch_taken) begin
                ctl_c.ifid_flush = 1'b1;
                ctl_c.idex_flush = 1'b1;
            end else if (lu_c) begin
                ctl_c.pc_wen     = 1'b0;
                ctl_c.ifid_wen   = 1'b0;
                ctl_c.idex_flush = 1'b1;
                bubble_c         = 1'b1;
            end else if (id_mdu_start) begin
                mdu_cnt_nxt = MDU_CNT_W'(MDU_LAT - 1);
                state_nxt   = ST_MDU;
            end
        end
    end

    assign pc_wen      = ctl_c.pc_wen;
    assign ifid_wen    = ctl_c.ifid_wen;
    assign idex_wen    = ctl_c.idex_wen;
    assign exmem_wen   = ctl_c.exmem_wen;
    assign ifid_flush  = ctl_c.ifid_flush;
    assign idex_flush  = ctl_c.idex_flush;
    assign exmem_flush = ctl_c.exmem_flush;
    assign state       = state_q;

`ifdef HAZ_STATS_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    // Saturating counts of PC-stalled cycles and load-use bubbles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (!ctl_c.pc_wen && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (bubble_c && (bubble_q != '1)) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign bubble_cnt   = bubble_q;
`else
    logic [CNT_W-1:0] unused_stats;
    assign unused_stats = CNT_W'(bubble_c);
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; stats checks apply with HAZ_STATS_EN.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MDU_LAT = 4;
    localparam int unsigned CNT_W   = 32;

    // {pc, ifid, idex, exmem wen | ifid, idex, exmem flush}
    localparam logic [6:0] C_DEF = 7'b1111_000;
    localparam logic [6:0] C_RST = 7'b0000_111;
    localparam logic [6:0] C_FRZ = 7'b0000_000;
    localparam logic [6:0] C_LU  = 7'b0011_010;
    localparam logic [6:0] C_BR  = 7'b1111_110;
    localparam logic [6:0] C_MDU = 7'b0001_001;

    logic             clock = 1'b0;
    logic             reset;
    logic [4:0]       id_rs, id_rt, ex_rd;
    logic             id_uses_rt, id_mdu_start, ex_mem_ren, ex_branch_taken;
    logic             mem_req, mem_ready;
    logic             pc_wen, ifid_wen, idex_wen, exmem_wen;
    logic             ifid_flush, idex_flush, exmem_flush;
    logic [1:0]       state;
`ifdef HAZ_STATS_EN
    logic [CNT_W-1:0] stall_cycles, bubble_cnt;
`endif

    logic [6:0] ctl;
    assign ctl = {pc_wen, ifid_wen, idex_wen, exmem_wen, ifid_flush, idex_flush, exmem_flush};

    int n_chk = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clock           (clock),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_mdu_start    (id_mdu_start),
        .ex_mem_ren      (ex_mem_ren),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_wen          (pc_wen),
        .ifid_wen        (ifid_wen),
        .idex_wen        (idex_wen),
        .exmem_wen       (exmem_wen),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .state           (state)
`ifdef HAZ_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .bubble_cnt      (bubble_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_uses_rt = 1'b0; id_mdu_start = 1'b0; ex_mem_ren = 1'b0;
        ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Next cycle: inputs are applied at the falling edge
    task automatic next();
        @(negedge clock);
        idle();
    endtask

    // Let combinational outputs settle, then compare controls and state
    task automatic expect_out(input string tag, input logic [6:0] c, input logic [1:0] s);
        #2;
        chk({tag, ".ctl"}, 32'(ctl), 32'(c));
        chk({tag, ".st"}, 32'(state), 32'(s));
    endtask

    task automatic expect_stats(input string tag, input int st, input int bu);
`ifdef HAZ_STATS_EN
        chk({tag, ".stall"}, stall_cycles, 32'(st));
        chk({tag, ".bubble"}, bubble_cnt, 32'(bu));
`else
        if (tag.len() < 0 || st < 0 || bu < 0) $display("unreachable");
`endif
    endtask

    initial begin
        reset = 1'b0;
        idle();

        // In reset
        next();
        expect_out("rst", C_RST, 2'd0);

        // First cycle after release
        next(); reset = 1'b1;
        expect_out("rel", C_DEF, 2'd0);
        expect_stats("rel", 0, 0);

        // Load-use on rs: one bubble
        next(); ex_mem_ren = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_rt = 5'd3;
        expect_out("lu_rs", C_LU, 2'd0);
        next();
        expect_out("lu_rs_after", C_DEF, 2'd0);
        expect_stats("lu_rs", 1, 1);

        // Load-use on rt only when rt is a source
        next(); ex_mem_ren = 1'b1; ex_rd = 5'd7; id_rs = 5'd1; id_rt = 5'd7; id_uses_rt = 1'b1;
        expect_out("lu_rt", C_LU, 2'd0);
        next(); ex_mem_ren = 1'b1; ex_rd = 5'd7; id_rs = 5'd1; id_rt = 5'd7;
        expect_out("lu_rt_unused", C_DEF, 2'd0);

        // Load to $0 never stalls
        next(); ex_mem_ren = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        expect_out("lu_r0", C_DEF, 2'd0);

        // Taken branch beats load-use, no bubble counted
        next(); ex_mem_ren = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; ex_branch_taken = 1'b1;
        expect_out("br_lu", C_BR, 2'd0);
        next();
        expect_stats("br_lu", 2, 2);

        // MDU start: three held cycles, branch/start ignored while busy
        next(); id_mdu_start = 1'b1;
        expect_out("mdu_go", C_DEF, 2'd0);
        next(); ex_branch_taken = 1'b1; id_mdu_start = 1'b1;
        expect_out("mdu_1", C_MDU, 2'd1);
        next();
        expect_out("mdu_2", C_MDU, 2'd1);
        next();
        expect_out("mdu_3", C_MDU, 2'd1);
        next();
        expect_out("mdu_done", C_DEF, 2'd0);
        expect_stats("mdu", 5, 2);

        // MDU with a three-cycle memory freeze in the middle
        next(); id_mdu_start = 1'b1;
        expect_out("mf_go", C_DEF, 2'd0);
        next();
        expect_out("mf_1", C_MDU, 2'd1);
        for (int i = 0; i < 3; i++) begin
            next(); mem_req = 1'b1;
            expect_out($sformatf("mf_frz%0d", i), C_FRZ, 2'd1);
        end
        next();
        expect_out("mf_2", C_MDU, 2'd1);
        next();
        expect_out("mf_3", C_MDU, 2'd1);
        next();
        expect_out("mf_done", C_DEF, 2'd0);
        expect_stats("mf", 11, 2);

        // Memory wait from RUN; release cycle acts like RUN (branch)
        next(); mem_req = 1'b1;
        expect_out("mw_0", C_FRZ, 2'd0);
        next(); mem_req = 1'b1;
        expect_out("mw_1", C_FRZ, 2'd2);
        next(); mem_req = 1'b1; mem_ready = 1'b1; ex_branch_taken = 1'b1;
        expect_out("mw_rel", C_BR, 2'd2);
        expect_stats("mw", 13, 2);
        next();
        expect_out("mw_run", C_DEF, 2'd0);

        // Reset pulled mid-MEM_WAIT
        next(); mem_req = 1'b1;
        expect_out("rw_0", C_FRZ, 2'd0);
        next(); mem_req = 1'b1;
        expect_out("rw_1", C_FRZ, 2'd2);
        #1 reset = 1'b0;
        expect_out("rw_rst", C_RST, 2'd0);
        next(); reset = 1'b1;
        expect_out("rw_rel", C_DEF, 2'd0);
        expect_stats("rw_rel", 0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
